// File: rtl/mul_div_unit_pkg.sv
// Shared opcode encodings and decode helpers for the multiply/divide unit.
// The EXE_*_OP values match the encodings used by the ALU and decoder.
package mul_div_unit_pkg;

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  function automatic logic op_is_mul(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

  function automatic logic op_is_div(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic op_is_signed(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_div.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// The caller sequences load/step and decides when the result is final.
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Next partial remainder / quotient for load and step
  always_comb begin
    shift_s = {rem_q, quo_q[WIDTH-1]};
    ge_s    = (shift_s >= {1'b0, dvs_q});
    // Only used when ge_s, where the true difference always fits in WIDTH bits
    diff_s  = shift_s[WIDTH-1:0] - dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    if (load_i) begin
      rem_d = {WIDTH{1'b0}};
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      if (ge_s) begin
        rem_d = diff_s;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shift_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_d = rem_q;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= {WIDTH{1'b0}};
      quo_q <= {WIDTH{1'b0}};
      dvs_q <= {WIDTH{1'b0}};
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Iterative ops take WIDTH+1 edges; MTHI/MTLO write in a single edge.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;

  logic               is_mul_s, is_div_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic               div_load_s, div_step_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  iter_div #(.WIDTH(WIDTH)) u_iter_div (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (div_load_s),
    .step_i      (div_step_s),
    .dividend_i  (a_mag_s),
    .divisor_i   (b_mag_s),
    .quotient_o  (quo_s),
    .remainder_o (rem_s)
  );

  // Operand decode, magnitudes and multiplier datapath
  always_comb begin
    is_mul_s   = op_is_mul(op);
    is_div_s   = op_is_div(op);
    a_neg_s    = op_is_signed(op) & a[WIDTH-1];
    b_neg_s    = op_is_signed(op) & b[WIDTH-1];
    a_mag_s    = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
    b_mag_s    = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
    mul_sum_s  = {1'b0, acc_q} + {1'b0, (mplr_q[0] ? mcand_q : {WIDTH{1'b0}})};
    prod_s     = {acc_q, mplr_q};
    prod_fix_s = neg_res_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
  end

  // FSM next state, HI/LO writes and handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    mplr_d     = mplr_q;
    mcand_d    = mcand_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    div0_d     = div0_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_load_s = 1'b0;
    div_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          busy_d = 1'b0;
        end else if (start && (is_mul_s || is_div_s)) begin
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          is_div_d   = is_div_s;
          div0_d     = (b == {WIDTH{1'b0}});
          neg_res_d  = a_neg_s ^ b_neg_s;
          neg_rem_d  = a_neg_s;
          a_raw_d    = a;
          mcand_d    = a_mag_s;
          mplr_d     = b_mag_s;
          acc_d      = {WIDTH{1'b0}};
          div_load_s = is_div_s;
        end else if (start && (op == EXE_MTHI_OP)) begin
          hi_d = a;
        end else if (start && (op == EXE_MTLO_OP)) begin
          lo_d = a;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            div_step_s = 1'b1;
          end else begin
            acc_d  = mul_sum_s[WIDTH:1];
            mplr_d = {mul_sum_s[0], mplr_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (flush) begin
          done_d = 1'b0;
        end else if (!is_div_q) begin
          hi_d   = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d   = prod_fix_s[WIDTH-1:0];
          done_d = 1'b1;
        end else if (div0_q) begin
          // Divide by zero bypasses the sign fix and returns the raw dividend
          hi_d   = a_raw_q;
          lo_d   = {WIDTH{1'b1}};
          done_d = 1'b1;
        end else begin
          hi_d   = neg_rem_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
          lo_d   = neg_res_q ? ({WIDTH{1'b0}} - quo_s) : quo_s;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, control and architectural registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      mplr_q    <= {WIDTH{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      a_raw_q   <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      mcand_q   <= mcand_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed plan cases plus random ops
// checked against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [7:0]   op = 8'h00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0]  exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_iter(input logic [7:0] o);
    return (o == EXE_MULT_OP) || (o == EXE_MULTU_OP) || (o == EXE_DIV_OP) || (o == EXE_DIVU_OP);
  endfunction

  // Reference model: {hi, lo} computed with plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sp;
    int     sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    if (o == EXE_MULT_OP) begin
      sp = longint'(sx) * longint'(sy);
      return 64'(sp);
    end else if (o == EXE_MULTU_OP) begin
      return {32'd0, x} * {32'd0, y};
    end else if (y == 32'd0) begin
      return {x, 32'hFFFF_FFFF};
    end else if (o == EXE_DIV_OP) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      return {32'(sx % sy), 32'(sx / sy)};
    end else begin
      return {x % y, x / y};
    end
  endfunction

  // Monitor: every done pulse pops one expected result and its due cycle.
  always @(negedge clk) begin
    if (resetn && done) begin
      check("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
        check("done_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [63:0] e);
    op = o; a = x; b = y; start = 1'b1;
    e = ref_model(o, x, y);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + W + 2);
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < W + 8) begin
      check("hilo_stable_run", {hi, lo}, {hi_m, lo_m});
      tick();
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    if (is_iter(o)) begin
      issue(o, x, y, e);
      wait_idle();
      hi_m = e[63:32];
      lo_m = e[31:0];
    end else begin
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      if (o == EXE_MTHI_OP) hi_m = x;
      else if (o == EXE_MTLO_OP) lo_m = x;
      check("busy_single", 64'(busy), 64'd0);
      check("hilo_single", {hi, lo}, {hi_m, lo_m});
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] e;
    logic [7:0]  ops [7];
    ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP, 8'h20};

    #1;
    check("reset_state", {hi, lo, 31'd0, busy}, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Directed plan cases; consecutive run_op calls are back-to-back in the done cycle.
    run_op(EXE_MULT_OP,  32'hFFFF_FFFE, 32'd3);
    run_op(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3);
    run_op(EXE_DIV_OP,   32'hFFFF_FFF9, 32'd2);
    run_op(EXE_DIVU_OP,  32'd7, 32'd2);
    run_op(EXE_DIV_OP,   32'h1234_5678, 32'd0);
    run_op(EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(EXE_DIVU_OP,  32'h8765_4321, 32'd0);

    // Flush mid-divide keeps HI/LO and produces no done.
    run_op(EXE_MTHI_OP, 32'hAAAA_0000, 32'd0);
    op = EXE_DIV_OP; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_before_flush", 64'(busy), 64'd1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(hi), 64'hAAAA_0000);
    run_op(EXE_DIVU_OP, 32'd100, 32'd7);

    // Flush beats a simultaneous start, including MTHI.
    op = EXE_MULT_OP; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    check("flush_vs_start", 64'(busy), 64'd0);
    op = EXE_MTHI_OP; a = 32'h1234_0000;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_vs_mthi", {hi, lo}, {hi_m, lo_m});

    // MTLO while busy is ignored; MTLO in idle takes effect.
    issue(EXE_MULTU_OP, 32'd9, 32'd11, e);
    op = EXE_MTLO_OP; a = 32'd5; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check("mtlo_while_busy", 64'(lo), 64'(lo_m));
    wait_idle();
    hi_m = e[63:32];
    lo_m = e[31:0];
    run_op(EXE_MTLO_OP, 32'd5, 32'd0);

    // Asynchronous reset mid-multiply clears everything immediately.
    issue(EXE_MULT_OP, 32'h1357_9BDF, 32'h0246_8ACE, e);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check("async_reset_hilo", {hi, lo}, 64'd0);
    check("async_reset_flags", {62'd0, busy, done}, 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    hi_m = '0;
    lo_m = '0;
    tick();
    resetn = 1'b1;
    tick();
    run_op(EXE_MULTU_OP, 32'd6, 32'd7);
    run_op(EXE_MULT_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Randomised mix of all opcodes, including an unrecognised one.
    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(0, 6)], rnd_operand(), rnd_operand());
    end

    tick(); tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle ALU in the execute stage. It executes MULT, MULTU, DIV, DIVU iteratively over WIDTH cycles and MTHI/MTLO in one cycle. It exposes busy/done handshakes so the pipeline controller can stall and flush.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  8  opcode, EXE_*_OP encoding; MULT, MULTU, DIV, DIVU, MTHI, MTLO are recognised, all others are ignored.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  synchronous abort (exception/branch flush).
- busy  out  1  registered; high while an iterative op is in flight.
- done  out  1  registered; one-cycle pulse when HI/LO are written by an iterative op.
- hi  out  WIDTH  registered HI.
- lo  out  WIDTH  registered LO.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: start & mul/div op → latch |a|, |b|, result signs, and op class; counter=0; → RUN; busy=1.
- IDLE: start & MTHI → hi<=a. start & MTLO → lo<=a. Both take one edge, with no busy and no done.
- RUN, multiply: radix-2 shift-add, one bit per cycle. {acc,mplr} is 2·WIDTH wide.
- RUN, divide: restoring division, one quotient bit per cycle. The partial remainder is WIDTH+1 bits.
- RUN: after WIDTH iterations (counter==WIDTH-1 at the edge) → FIX.
- FIX: apply the sign fix and write HI/LO. Then → IDLE, busy<=0, done<=1 for one cycle.
- Signed ops work on magnitudes:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned ops: no sign fix.
- Multiply writes hi=product[2W-1:W] and lo=product[W-1:0].
- Divide writes lo=quotient and hi=remainder.
- Divide by zero (b==0, signed or unsigned): lo=all ones, hi=a unmodified, no sign fix. The op still takes the full latency.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0. The result wraps with no trap.
- start while busy=1 is ignored. The controller holds the instruction until busy falls.
- flush in any state: next edge → IDLE, busy=0, done=0. HI/LO keep their previous values, and a same-cycle MTHI/MTLO is suppressed.
- flush wins over a simultaneous start.
- resetn=0 at any time, including mid-op: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.

## Timing
- Iterative op accepted at edge E0 → busy=1 after E0. RUN spans edges E1..E_WIDTH, FIX is at E_WIDTH+1.
- After E_WIDTH+1: hi/lo updated, done=1, busy=0. Latency is WIDTH+1 edges (33 at WIDTH=32).
- done is high in IDLE. A new start in the done cycle is accepted at E_WIDTH+2, giving back-to-back throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO accepted at edge E0 → hi/lo updated after E0.
- hi/lo never change during RUN. Internal accumulators are private, so readers see old values until done.

## Structure
- Add EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP to defines.vh, shared with alu and the decoder.
- FSM state encodings are local parameters in mul_div_unit.
- One sub-module: iter_div. It holds the restoring-division datapath (WIDTH parameter, load/step inputs, quotient/remainder outputs).
- The shift-add multiplier, sign handling, FSM and HI/LO registers stay in mul_div_unit.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → done after 33 edges, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0xAAAA0000 via MTHI. Start DIV, assert flush 10 edges later → busy=0 next cycle, no done, hi still 0xAAAA0000. Start the next cycle → accepted.
- MTLO a=0x5 asserted while busy → ignored, lo unchanged. MTLO in IDLE → lo=0x5 after one edge, busy stays 0.
- Assert resetn=0 mid-MULT → hi=lo=0, busy=done=0 immediately. Release and issue MULTU 6×7 → lo=42, hi=0. Also run a back-to-back start in the done cycle and check the second result.
